// File: rtl/timer_rtc_pkg.sv
// Shared definitions for the RTC timer register senders and capture logic.
// Addresses, BCD limits and the transmit state encoding.
package timer_rtc_pkg;

    localparam logic [7:0] RTC_ADDR_SEG  = 8'h41;
    localparam logic [7:0] RTC_ADDR_MIN  = 8'h42;
    localparam logic [7:0] RTC_ADDR_HORA = 8'h43;
    localparam logic [7:0] RTC_ADDR_CMD  = 8'hF0;
    localparam logic [7:0] RTC_CMD_XFER  = 8'hF0;

    localparam logic [7:0] BCD_MAX_MS = 8'h59;
    localparam logic [7:0] BCD_MAX_H  = 8'h23;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        REQ,
        WAIT_LOW,
        NEXT,
        DONE
    } tx_state_e;

    function automatic logic bcd_valid(
        input logic [7:0] value,
        input logic [7:0] max
    );
        return (value[7:4] <= 4'd9) &&
               (value[3:0] <= 4'd9) &&
               (value <= max);
    endfunction

endpackage

// File: rtl/escritura_timer_tx.sv
// Timer register sender: snapshots BCD seconds/minutes/hours and writes them
// to the RTC bus driver, followed by the transfer command.
module escritura_timer_tx
    import timer_rtc_pkg::*;
#(
    parameter logic [7:0] ADDR_SEG    = RTC_ADDR_SEG,
    parameter logic [7:0] ADDR_MIN    = RTC_ADDR_MIN,
    parameter logic [7:0] ADDR_HORA   = RTC_ADDR_HORA,
    parameter logic [7:0] ADDR_CMD    = RTC_ADDR_CMD,
    parameter logic [7:0] CMD_DATA    = RTC_CMD_XFER,
    parameter int         ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] seg_t,
    input  logic [7:0] min_t,
    input  logic [7:0] hora_t,
    output logic       wr_req,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic       wr_ack,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    tx_state_e     state;
    logic [1:0]    idx;
    logic [7:0]    seg_q;
    logic [7:0]    min_q;
    logic [7:0]    hora_q;
    logic [CW-1:0] cnt;
    logic [7:0]    sel_addr;
    logic [7:0]    sel_data;
    logic          snap_ok;

    assign snap_ok = bcd_valid(seg_q, BCD_MAX_MS) &&
                     bcd_valid(min_q, BCD_MAX_MS) &&
                     bcd_valid(hora_q, BCD_MAX_H);

    always_comb begin
        sel_addr = ADDR_CMD;
        sel_data = CMD_DATA;
        unique case (idx)
            2'd0: begin
                sel_addr = ADDR_SEG;
                sel_data = seg_q;
            end
            2'd1: begin
                sel_addr = ADDR_MIN;
                sel_data = min_q;
            end
            2'd2: begin
                sel_addr = ADDR_HORA;
                sel_data = hora_q;
            end
            default: begin
                sel_addr = ADDR_CMD;
                sel_data = CMD_DATA;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= 2'd0;
            seg_q   <= 8'h00;
            min_q   <= 8'h00;
            hora_q  <= 8'h00;
            cnt     <= '0;
            wr_req  <= 1'b0;
            wr_addr <= 8'h00;
            wr_data <= 8'h00;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        seg_q  <= seg_t;
                        min_q  <= min_t;
                        hora_q <= hora_t;
                        error  <= 1'b0;
                        idx    <= 2'd0;
                        busy   <= 1'b1;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (snap_ok) begin
                        wr_req  <= 1'b1;
                        wr_addr <= sel_addr;
                        wr_data <= sel_data;
                        cnt     <= '0;
                        state   <= REQ;
                    end else begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                REQ: begin
                    if (wr_ack) begin
                        wr_req <= 1'b0;
                        cnt    <= '0;
                        state  <= WAIT_LOW;
                    end else if (cnt == CNT_LAST) begin
                        wr_req <= 1'b0;
                        error  <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_LOW: begin
                    if (!wr_ack) begin
                        if (idx == 2'd3) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx   <= idx + 2'd1;
                            state <= NEXT;
                        end
                    end else if (cnt == CNT_LAST) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // Idle gap so the driver always sees wr_req low between writes
                NEXT: begin
                    wr_req  <= 1'b1;
                    wr_addr <= sel_addr;
                    wr_data <= sel_data;
                    cnt     <= '0;
                    state   <= REQ;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
